// File: rtl/if_id_queue.sv
// IF/ID instruction buffer: small circular FIFO of {pc, instr} pairs between fetch and decode.
// Flush drops every buffered entry on a redirect; the head is presented combinationally to decode.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_pc,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [63:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;
    logic [63:0]   head_s;

    // Handshake qualifiers and head presentation; a full queue never accepts, even alongside a pop.
    always_comb begin
        in_ready  = (count_r != DEPTH_C);
        out_valid = (count_r != {(AW + 1){1'b0}});
        push_s    = in_valid & in_ready;
        pop_s     = out_valid & out_ready;
        head_s    = mem_r[rd_ptr_r];
        count     = count_r;
        if (out_valid) begin
            out_instr = head_s[31:0];
            out_pc    = head_s[63:32];
        end else begin
            out_instr = 32'h0000_0000;
            out_pc    = 32'h0000_0000;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (reset && !flush && push_s) begin
            mem_r[wr_ptr_r] <= {in_pc, in_instr};
        end
    end

    // Pointer and occupancy update: reset, then flush, then push/pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                    count_r  <= count_r + CNT_ONE;
                end
                2'b01: begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                    count_r  <= count_r - CNT_ONE;
                end
                2'b11: begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                default: begin
                    wr_ptr_r <= wr_ptr_r;
                    rd_ptr_r <= rd_ptr_r;
                    count_r  <= count_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed vector table, hand-written latency/stream
// sequences, and randomized traffic against a queue-based reference model.
module tb_if_id_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int checks;
    int failures;

    if_id_queue #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit          fl;
        bit          iv;
        logic [31:0] pc;
        bit          ordy;
        bit          e_valid;
        logic [31:0] e_pc;
        int          e_cnt;
        bit          e_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'h2408_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input bit rst_n, input bit fl, input bit iv, input logic [31:0] pc,
                       input bit ordy, input bit ev, input logic [31:0] epc, input int ecnt,
                       input bit erdy);
        vec_t v;
        v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.e_valid = ev; v.e_pc = epc; v.e_cnt = ecnt; v.e_rdy = erdy;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input bit ev, input logic [31:0] epc,
                                 input int ecnt, input bit erdy);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, ".out_pc"}, 64'(out_pc), 64'(ev ? epc : 32'h0));
        chk({tag, ".out_instr"}, 64'(out_instr), 64'(ev ? instr_of(epc) : 32'h0));
        chk({tag, ".count"}, 64'(count), 64'(ecnt));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(erdy));
    endtask

    task automatic drive(input bit rst_n, input bit fl, input bit iv, input logic [31:0] pc,
                         input bit ordy);
        reset = rst_n; flush = fl; in_valid = iv; in_pc = pc; in_instr = instr_of(pc);
        out_ready = ordy;
    endtask

    // reference model state
    logic [63:0] q[$];

    initial begin
        bit          hold;
        bit          m_push;
        bit          m_pop;
        logic [31:0] rpc;

        checks = 0;
        failures = 0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Directed table
        add(0, 0, 0, 32'h0,    0, 0, 32'h0,    0, 1);
        add(1, 0, 1, 32'h3000, 0, 1, 32'h3000, 1, 1);
        add(1, 0, 1, 32'h3004, 0, 1, 32'h3000, 2, 1);
        add(1, 0, 1, 32'h3008, 0, 1, 32'h3000, 3, 1);
        add(1, 0, 1, 32'h300C, 0, 1, 32'h3000, 4, 0);
        add(1, 0, 1, 32'h3010, 0, 1, 32'h3000, 4, 0);
        add(1, 0, 0, 32'h0,    1, 1, 32'h3004, 3, 1);
        add(1, 0, 0, 32'h0,    1, 1, 32'h3008, 2, 1);
        add(1, 0, 0, 32'h0,    1, 1, 32'h300C, 1, 1);
        add(1, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1);
        add(1, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1);
        add(1, 0, 1, 32'h3200, 0, 1, 32'h3200, 1, 1);
        add(1, 0, 1, 32'h3204, 0, 1, 32'h3200, 2, 1);
        add(1, 0, 1, 32'h3208, 0, 1, 32'h3200, 3, 1);
        add(0, 0, 1, 32'h320C, 1, 0, 32'h0,    0, 1);
        add(1, 0, 0, 32'h0,    0, 0, 32'h0,    0, 1);
        add(1, 0, 1, 32'h3300, 0, 1, 32'h3300, 1, 1);
        add(1, 0, 1, 32'h3304, 0, 1, 32'h3300, 2, 1);
        add(1, 0, 1, 32'h3308, 0, 1, 32'h3300, 3, 1);
        add(1, 1, 1, 32'h3020, 1, 0, 32'h0,    0, 1);
        add(1, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1);
        add(1, 0, 1, 32'h3030, 0, 1, 32'h3030, 1, 1);
        add(1, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1);
        add(1, 0, 1, 32'h3040, 0, 1, 32'h3040, 1, 1);
        add(1, 0, 1, 32'h3044, 0, 1, 32'h3040, 2, 1);
        add(1, 0, 1, 32'h3048, 0, 1, 32'h3040, 3, 1);
        add(1, 0, 1, 32'h304C, 0, 1, 32'h3040, 4, 0);
        add(1, 0, 1, 32'h3050, 1, 1, 32'h3044, 3, 1);
        add(1, 0, 1, 32'h3050, 0, 1, 32'h3044, 4, 0);
        add(1, 0, 0, 32'h0,    1, 1, 32'h3048, 3, 1);
        add(1, 0, 0, 32'h0,    1, 1, 32'h304C, 2, 1);
        add(1, 0, 0, 32'h0,    1, 1, 32'h3050, 1, 1);
        add(1, 0, 0, 32'h0,    1, 0, 32'h0,    0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                          vecs[i].e_cnt, vecs[i].e_rdy);
        end

        // Single push latency: head must not appear in the same cycle as the push
        drive(1'b1, 1'b0, 1'b1, 32'h3000, 1'b0);
        in_instr = 32'h2408_0005;
        #1;
        chk("lat.same_cycle_valid", 64'(out_valid), 64'(1'b0));
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("lat.next_valid", 64'(out_valid), 64'(1'b1));
        chk("lat.next_instr", 64'(out_instr), 64'(32'h2408_0005));
        chk("lat.next_pc", 64'(out_pc), 64'(32'h3000));
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("lat.drained", 64'(count), 64'(0));

        // Steady stream through a pointer wrap, occupancy pinned at one
        drive(1'b1, 1'b0, 1'b1, 32'h3100, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h3104 + 32'(4 * i), 1'b1);
            #1;
            chk($sformatf("stream%0d.pc", i), 64'(out_pc), 64'(32'h3100 + 32'(4 * i)));
            tick();
            chk($sformatf("stream%0d.count", i), 64'(count), 64'(1));
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        chk("stream.drained", 64'(out_valid), 64'(1'b0));

        // Randomized traffic against the reference model (queue starts empty here)
        q.delete();
        hold = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!hold) begin
                rpc = {$urandom_range(0, 65535), 2'b00} + 32'h0040_0000;
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc = rpc;
                in_instr = $urandom;
            end
            reset = ($urandom_range(0, 49) != 0);
            flush = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            chk("rnd.valid", 64'(out_valid), 64'(q.size() != 0));
            chk("rnd.pc", 64'(out_pc), 64'((q.size() != 0) ? q[0][63:32] : 32'h0));
            chk("rnd.instr", 64'(out_instr), 64'((q.size() != 0) ? q[0][31:0] : 32'h0));
            chk("rnd.count", 64'(count), 64'(q.size()));
            chk("rnd.ready", 64'(in_ready), 64'(q.size() != 4));
            m_push = in_valid && (q.size() != 4);
            m_pop  = out_ready && (q.size() != 0);
            hold   = in_valid && !m_push && reset && !flush;
            tick();
            if (!reset || flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back({in_pc, in_instr});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction buffer between the fetch stage (PC register plus instruction memory) and the decode stage of the 5-stage MIPS pipeline.
- Captures {instr, pc} pairs from fetch with a valid/ready handshake and holds them in a small circular FIFO.
- Presents the oldest pair to decode, decoupling fetch from decode stalls.
- A flush input discards every buffered entry when a redirect happens (branch/jump resolved, exception).

Parameters:
DEPTH, 4, number of entries; power of two, minimum 2
AW, 2, pointer width, log2(DEPTH); must match DEPTH

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
flush  input  1  discard all entries this cycle
in_valid  input  1  fetch presents a valid instruction
in_ready  output  1  queue can accept a push this cycle
in_instr  input  32  instruction word from instruction memory
in_pc  input  32  PC of in_instr
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes the head this cycle
out_instr  output  32  head instruction; 32'h0000_0000 (sll $0,$0,0 nop) when out_valid=0
out_pc  output  32  head PC; 32'h0 when out_valid=0
count  output  AW+1  number of valid entries, 0..DEPTH

Behaviour:
- Storage: DEPTH x 64-bit array {pc, instr}, plus wr_ptr and rd_ptr (AW bits, wrap modulo DEPTH) and count (AW+1 bits). Storage array has no reset requirement.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). Depends only on registered count, never on out_ready. A full queue refuses a push even if a pop happens in the same cycle.
- out_valid = (count != 0). out_instr/out_pc read combinationally from mem[rd_ptr] when out_valid=1, else forced to 0.
- Latency: an entry pushed at edge N is visible on out_* after edge N (1 cycle). There is no same-cycle bypass from in_* to out_*.
- Priority per rising edge (highest first):
  1. reset==0: wr_ptr=0, rd_ptr=0, count=0. After the edge: out_valid=0, out_instr=0, out_pc=0, in_ready=1.
  2. flush==1: wr_ptr=0, rd_ptr=0, count=0. Any concurrent push or pop is ignored; the pushed word is dropped. Next cycle: empty, in_ready=1.
  3. Otherwise:
     - push only: mem[wr_ptr]={in_pc,in_instr}, wr_ptr+1, count+1.
     - pop only: rd_ptr+1, count-1.
     - push and pop (possible only when 0<count<DEPTH): write, both pointers advance, count unchanged.
     - Neither: hold.
- Empty: a pop is impossible (out_valid=0). out_ready may be high with no effect.
- Full: in_ready=0. Fetch must hold its PC (stall). in_valid is ignored.
- Wrap-around: pointers roll from DEPTH-1 to 0. FIFO order is preserved across the wrap.
- Reset mid-operation: all content is lost; no partial outputs. Identical to the post-reset state.
- Handshake assumption on the fetch side: fetch holds in_instr/in_pc stable while in_valid=1 and in_ready=0. Decode may change out_ready freely.
- No combinational path from in_valid or in_* to out_*. out_ready feeds only state.

Test Plan:
- Reset with queue holding 3 entries, reset=0 for 1 edge -> count=0, out_valid=0, out_instr=0, out_pc=0, in_ready=1.
- Push PCs 0x3000,0x3004,0x3008,0x300C with out_ready=0 -> count=4, in_ready=0. A fifth push of PC 0x3010 is not accepted. Then pop 4 with out_ready=1 -> out_pc sequence 0x3000,0x3004,0x3008,0x300C, then out_valid=0.
- Single push of instr 0x24080005 at PC 0x3000 into empty queue -> out_valid rises the next cycle (not the same cycle), out_instr=0x24080005.
- Steady stream with in_valid=out_ready=1 after one prefill, 10 cycles -> count stays 1. out_pc increments by 4 each cycle through a pointer wrap with no loss or duplication.
- Queue holds 3 entries; flush=1 together with push of PC 0x3020 and out_ready=1 -> next cycle count=0, out_valid=0. PC 0x3020 never appears on out_pc.
- Full queue, same cycle out_ready=1 and in_valid=1 -> one pop occurs, no push, count=3. The held input is accepted on the following cycle and count returns to 4.
